pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the datapath payload width (instruction, data, address).
REQ-002 SHALL have parameter CTRL_W, default 16, the packed control-unit signal width.
REQ-003 SHALL have parameter EXC_W, default 2, the exception flag count (inst_misalign, mem_misalign, ...).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, upstream entry valid.
REQ-007 SHALL have port in_ready, output, 1, stage can accept an entry.
REQ-008 SHALL have ports in_data, input, DATA_W, and in_ctrl, input, CTRL_W, the entry payload.
REQ-009 SHALL have port in_halt, input, 1, decoded halt instruction.
REQ-010 SHALL have port in_exc, input, EXC_W, exception flags.
REQ-011 SHALL have port flush, input, 1, squash all held entries.
REQ-012 SHALL have ports out_valid, output, 1, and out_ready, input, 1, the downstream handshake.
REQ-013 SHALL have ports out_data, output, DATA_W, out_ctrl, output, CTRL_W, and out_exc, output, EXC_W, the held payload.
REQ-014 SHALL have port out_halt, output, 1, folded halt of the head entry.
REQ-015 SHALL have port occupancy, output, 2, held entry count (0..2).

Function
REQ-016 SHALL transfer on a port only when its valid and ready are both high at the clk rising edge.
REQ-017 SHALL store each accepted entry as {data, ctrl, exc, halt_f}, where halt_f = in_halt | (|in_exc), and SHALL fold exceptions into halt at capture.
REQ-018 SHALL present the oldest entry on out_* with one-cycle latency from acceptance into an empty stage.
REQ-019 SHALL preserve FIFO order; the second entry (skid) SHALL move to head on the edge the head is consumed.
REQ-020 SHALL allow a simultaneous accept and consume in one cycle with occupancy unchanged.
REQ-021 SHALL deassert in_ready when occupancy = 2, and SHALL ignore in_valid while in_ready is low.
REQ-022 SHALL set a sticky halt_seen when an entry with halt_f = 1 is accepted, SHALL hold in_ready low from the next cycle onward, and SHALL clear halt_seen only on flush or rst.
REQ-023 SHALL still drain entries already held while halt_seen is set.
REQ-024 SHALL, on flush, clear occupancy to 0 and halt_seen to 0 at the edge; flush SHALL take priority over a simultaneous accept or consume, and the incoming entry SHALL be discarded.
REQ-025 SHALL force out_valid = 0 whenever occupancy = 0; out_data, out_ctrl, out_exc and out_halt SHALL be zero when out_valid = 0.

Reset
REQ-026 SHALL, on rst high, asynchronously clear all storage, occupancy, out_valid, out_halt and halt_seen to 0; in_ready SHALL be 1 after reset release.
REQ-027 SHALL, on rst asserted mid-transfer, lose all held entries without producing any partial output.

Configuration
REQ-028 SHALL, with PIPE_SKID_EN defined, implement the two-entry skid with registered in_ready = (occupancy < 2) & ~halt_seen.
REQ-029 SHALL, without PIPE_SKID_EN, hold one entry only, with in_ready = (~out_valid | out_ready) & ~halt_seen (combinational path from out_ready), and occupancy never exceeding 1.

Structure
REQ-030 SHALL take the exception bit indices (EXC_INST_MISALIGN = 0, EXC_MEM_MISALIGN = 1) and the occupancy width constant from shared package pipe_pkg.
REQ-031 SHALL build its storage from sub-module pipe_entry_reg, a width-parametrised enable flop bank with asynchronous active-high reset; there SHALL be two instances under PIPE_SKID_EN and one without.

Verification
REQ-032 SHALL cover reset then in_valid=1, in_data=16'h1234, out_ready=1 -> out_valid=1, out_data=16'h1234 one cycle later; occupancy=1.
REQ-033 SHALL cover 16'hA, 16'hB accepted with out_ready=0 -> occupancy=2, in_ready=0; then out_ready=1 -> A, then B on consecutive cycles (PIPE_SKID_EN).
REQ-034 SHALL cover an entry accepted with in_exc=2'b10, in_halt=0 -> out_halt=1, out_exc=2'b10; in_ready=0 afterwards until flush.
REQ-035 SHALL cover flush asserted with occupancy=2 and in_valid=1 in the same cycle -> occupancy=0, out_valid=0 next cycle, incoming entry absent.
REQ-036 SHALL cover rst asserted asynchronously between edges with occupancy=2 -> out_valid=0 and occupancy=0 immediately, in_ready=1 after release.
REQ-037 SHALL cover a continuous stream of 8 entries with out_ready=1 -> one entry out per cycle, in order, with occupancy steady at 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, occupancy type and halt-fold helper for the pipeline stage
package pipe_pkg;

    localparam int EXC_INST_MISALIGN = 0;
    localparam int EXC_MEM_MISALIGN  = 1;

    localparam int OCC_W = 2;
    typedef logic [OCC_W-1:0] occ_t;

    localparam occ_t OCC_EMPTY = occ_t'(0);
    localparam occ_t OCC_ONE   = occ_t'(1);
    localparam occ_t OCC_FULL  = occ_t'(2);

    // Any exception stops further issue exactly like a decoded halt.
    function automatic logic fold_halt(input logic halt, input logic any_exc);
        return halt | any_exc;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - width-parametrised enable flop bank with async active-high reset
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage with halt folding; PIPE_SKID_EN selects two-entry skid
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 16,
    parameter int EXC_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_halt,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_halt,
    output logic [OCC_W-1:0]  occupancy
);

    // Entry layout, MSB first: {data, ctrl, exc, halt_f}.
    localparam int ENT_W = DATA_W + CTRL_W + EXC_W + 1;

    occ_t             occ_q;
    logic             halt_seen_q;
    logic [ENT_W-1:0] in_entry;
    logic [ENT_W-1:0] head_d;
    logic [ENT_W-1:0] head_q;
    logic             head_en;
    logic             accept;
    logic             consume;

    assign in_entry  = {in_data, in_ctrl, in_exc, fold_halt(in_halt, |in_exc)};
    assign out_valid = (occ_q != OCC_EMPTY);
    assign consume   = out_valid & out_ready;
    assign accept    = in_valid & in_ready;
    assign occupancy = occ_q;

`ifdef PIPE_SKID_EN
    logic [ENT_W-1:0] skid_q;
    logic             skid_en;

    // Ready depends on held state only, so no path from out_ready.
    assign in_ready = (occ_q != OCC_FULL) & ~halt_seen_q;
    assign head_d   = (occ_q == OCC_FULL) ? skid_q : in_entry;
    assign head_en  = ~flush & ((accept & ((occ_q == OCC_EMPTY) | consume)) |
                                ((occ_q == OCC_FULL) & consume));
    assign skid_en  = ~flush & accept & ~consume & (occ_q == OCC_ONE);

    pipe_entry_reg #(.W(ENT_W)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_entry),
        .q   (skid_q)
    );
`else
    assign in_ready = (~out_valid | out_ready) & ~halt_seen_q;
    assign head_d   = in_entry;
    assign head_en  = ~flush & accept;
`endif

    pipe_entry_reg #(.W(ENT_W)) u_head (
        .clk (clk),
        .rst (rst),
        .en  (head_en),
        .d   (head_d),
        .q   (head_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q       <= OCC_EMPTY;
            halt_seen_q <= 1'b0;
        end else if (flush) begin
            occ_q       <= OCC_EMPTY;
            halt_seen_q <= 1'b0;
        end else begin
            occ_q <= occ_q + occ_t'(accept) - occ_t'(consume);
            if (accept && in_entry[0]) begin
                halt_seen_q <= 1'b1;
            end
        end
    end

    // Stale storage is never visible once the stage is empty.
    assign out_data = out_valid ? head_q[ENT_W-1 -: DATA_W]        : '0;
    assign out_ctrl = out_valid ? head_q[EXC_W+CTRL_W -: CTRL_W]   : '0;
    assign out_exc  = out_valid ? head_q[EXC_W -: EXC_W]           : '0;
    assign out_halt = out_valid & head_q[0];

endmodule
